// File: rtl/ram_pkg.sv
// Shared definitions for the parametrised single-port RAM and its clear engine.
package ram_pkg;

  localparam int BYTE_W  = 8;
  localparam int RDW_NEW = 0;
  localparam int RDW_OLD = 1;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } ram_state_t;

endpackage

// File: rtl/ram_clear_fsm.sv
// Clear engine: sweeps INIT_VALUE through every word after reset or a clr pulse,
// and muxes the single write port between the sweep and user writes.
module ram_clear_fsm
  import ram_pkg::*;
#(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 6,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         we,
  input  logic [ADDR_WIDTH-1:0]        addr,
  input  logic [DATA_WIDTH-1:0]        data,
  input  logic [DATA_WIDTH/BYTE_W-1:0] be,
  output logic                         ready,
  output logic                         wr_drop,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  output logic [DATA_WIDTH-1:0]        mem_data,
  output logic [DATA_WIDTH/BYTE_W-1:0] mem_lane_en
);

  ram_state_t            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  wr_drop_q, wr_drop_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_drop_d = 1'b0;
    case (state_q)
      CLEAR: begin
        cnt_d     = cnt_q + ADDR_WIDTH'(1);
        wr_drop_d = we;
        if (&cnt_q) begin
          state_d = READY;
        end
      end
      READY: begin
        if (clr) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      cnt_q     <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  // The reset edge writes nothing, so contents survive reset until the sweep reaches them.
  always_comb begin
    mem_addr    = addr;
    mem_data    = data;
    mem_lane_en = '0;
    if (!rst) begin
      if (state_q == CLEAR) begin
        mem_addr    = cnt_q;
        mem_data    = INIT_VALUE;
        mem_lane_en = '1;
      end else if (we) begin
        mem_lane_en = be;
      end
    end
  end

  assign ready   = (state_q == READY);
  assign wr_drop = wr_drop_q;

endmodule

// File: rtl/param_sp_ram.sv
// Parametrised single-port RAM with byte-lane writes, selectable read-during-write
// behaviour and a self-initialising clear engine.
module param_sp_ram
  import ram_pkg::*;
#(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 6,
  parameter int                    RDW_MODE   = 0,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_WIDTH-1:0]        data,
  input  logic [ADDR_WIDTH-1:0]        addr,
  input  logic                         we,
  input  logic [DATA_WIDTH/BYTE_W-1:0] be,
  input  logic                         clr,
  output logic [DATA_WIDTH-1:0]        q,
  output logic                         ready,
  output logic                         wr_drop
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int LANES = DATA_WIDTH / BYTE_W;

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data;
  logic [LANES-1:0]      mem_lane_en;
  logic [DATA_WIDTH-1:0] wr_word_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  ram_clear_fsm #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .INIT_VALUE (INIT_VALUE)
  ) u_clear_fsm (
    .clk         (clk),
    .rst         (rst),
    .clr         (clr),
    .we          (we),
    .addr        (addr),
    .data        (data),
    .be          (be),
    .ready       (ready),
    .wr_drop     (wr_drop),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .mem_lane_en (mem_lane_en)
  );

  // Disabled lanes keep the stored bytes, so a partial write is a read-merge of one word.
  always_comb begin
    wr_word_d = mem_q[mem_addr];
    for (int i = 0; i < LANES; i++) begin
      if (mem_lane_en[i]) begin
        wr_word_d[i*BYTE_W +: BYTE_W] = mem_data[i*BYTE_W +: BYTE_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (|mem_lane_en) begin
      mem_q[mem_addr] <= wr_word_d;
    end
  end

  if (RDW_MODE == RDW_OLD) begin : g_rdw_old
    logic [DATA_WIDTH-1:0] q_d, q_q;

    always_comb begin
      q_d = q_q;
      if (ready) begin
        q_d = mem_q[addr];
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        q_q <= '0;
      end else begin
        q_q <= q_d;
      end
    end

    assign q = ready ? q_q : '0;
  end else begin : g_rdw_new
    logic [ADDR_WIDTH-1:0] addr_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        addr_q <= '0;
      end else begin
        addr_q <= addr;
      end
    end

    // Reading the array through the registered address makes same-edge writes visible at once.
    assign q = ready ? mem_q[addr_q] : '0;
  end

endmodule

// File: tb/tb_param_sp_ram.sv
// Bench for param_sp_ram: a default 8-bit new-data instance and a 32-bit old-data
// instance share one stimulus stream and are checked against a behavioural model.
module tb_param_sp_ram;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic        clr;
  logic [5:0]  addr_in;
  logic [31:0] data_in;
  logic [3:0]  be_in;

  logic [7:0]  q_a;
  logic        ready_a;
  logic        wr_drop_a;
  logic [31:0] q_b;
  logic        ready_b;
  logic        wr_drop_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  param_sp_ram u_dut_a (
    .clk     (clk),
    .rst     (rst),
    .data    (data_in[7:0]),
    .addr    (addr_in),
    .we      (we),
    .be      (be_in[0:0]),
    .clr     (clr),
    .q       (q_a),
    .ready   (ready_a),
    .wr_drop (wr_drop_a)
  );

  param_sp_ram #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (6),
    .RDW_MODE   (1),
    .INIT_VALUE (32'hDEADBEEF)
  ) u_dut_b (
    .clk     (clk),
    .rst     (rst),
    .data    (data_in),
    .addr    (addr_in),
    .we      (we),
    .be      (be_in),
    .clr     (clr),
    .q       (q_b),
    .ready   (ready_b),
    .wr_drop (wr_drop_b)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic w, input logic c,
                               input logic [5:0] a, input logic [31:0] d, input logic [3:0] b);
    rst     = r;
    we      = w;
    clr     = c;
    addr_in = a;
    data_in = d;
    be_in   = b;
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: the clear is a countdown that fills the whole memory at once when it expires.
  logic        m_valid = 1'b0;
  logic        m_ready;
  logic        m_drop;
  int          m_left;
  logic [5:0]  m_addr;
  logic [31:0] m_qb;
  logic [7:0]  m_a [DEPTH];
  logic [31:0] m_b [DEPTH];

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b1;
      m_ready = 1'b0;
      m_drop  = 1'b0;
      m_left  = DEPTH;
      m_addr  = '0;
      m_qb    = '0;
    end else if (m_valid) begin
      m_addr = addr_in;
      if (!m_ready) begin
        m_drop = we;
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_ready = 1'b1;
          for (int i = 0; i < DEPTH; i++) begin
            m_a[i] = 8'h00;
            m_b[i] = 32'hDEADBEEF;
          end
        end
      end else begin
        m_drop = 1'b0;
        m_qb   = m_b[addr_in];
        if (we) begin
          if (be_in[0]) m_a[addr_in] = data_in[7:0];
          for (int j = 0; j < 4; j++) begin
            if (be_in[j]) m_b[addr_in][8*j +: 8] = data_in[8*j +: 8];
          end
        end
        if (clr) begin
          m_ready = 1'b0;
          m_left  = DEPTH;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      checkOutput("ready_a", 32'(ready_a), 32'(m_ready));
      checkOutput("ready_b", 32'(ready_b), 32'(m_ready));
      checkOutput("wr_drop_a", 32'(wr_drop_a), 32'(m_drop));
      checkOutput("wr_drop_b", 32'(wr_drop_b), 32'(m_drop));
      checkOutput("q_a", 32'(q_a), m_ready ? 32'(m_a[m_addr]) : 32'h0);
      checkOutput("q_b", q_b, m_ready ? m_qb : 32'h0);
    end
  end

  initial begin
    int cyc;

    applyStimulus(1'b1, 1'b0, 1'b0, 6'd0, 32'h0, 4'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 6'd0, 32'h0, 4'h0);
    checkOutput("rst_ready", 32'(ready_a), 32'h0);
    checkOutput("rst_wr_drop", 32'(wr_drop_b), 32'h0);
    checkOutput("rst_q_a", 32'(q_a), 32'h0);
    checkOutput("rst_q_b", q_b, 32'h0);

    cyc = 0;
    for (int i = 1; i <= 200 && cyc == 0; i++) begin
      applyStimulus(1'b0, i == 10, 1'b0, 6'd0, 32'h5A, 4'hF);
      if (i == 10) checkOutput("drop_pulse", 32'(wr_drop_a), 32'h1);
      if (i == 11) checkOutput("drop_clear", 32'(wr_drop_a), 32'h0);
      if (ready_a) cyc = i;
    end
    checkOutput("reset_clear_latency", 32'(cyc), 32'd64);

    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 6'(i), 32'h0, 4'h0);
      checkOutput("init_q_a", 32'(q_a), 32'h0);
      checkOutput("init_q_b", q_b, 32'hDEADBEEF);
    end

    applyStimulus(1'b0, 1'b1, 1'b0, 6'd5, 32'h11223344, 4'b0101);
    applyStimulus(1'b0, 1'b0, 1'b0, 6'd5, 32'h0, 4'h0);
    checkOutput("lane_q_b", q_b, 32'hDE22BE44);
    checkOutput("lane_q_a", 32'(q_a), 32'h44);

    applyStimulus(1'b0, 1'b1, 1'b0, 6'd3, 32'hAA, 4'hF);
    applyStimulus(1'b0, 1'b1, 1'b0, 6'd3, 32'h55, 4'hF);
    checkOutput("rdw_new_q_a", 32'(q_a), 32'h55);
    checkOutput("rdw_old_q_b", q_b, 32'hAA);
    applyStimulus(1'b0, 1'b0, 1'b0, 6'd3, 32'h0, 4'h0);
    checkOutput("rdw_old_next_q_b", q_b, 32'h55);

    applyStimulus(1'b0, 1'b1, 1'b0, 6'd7, 32'h3C, 4'hF);
    applyStimulus(1'b0, 1'b1, 1'b0, 6'd7, 32'hFF, 4'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 6'd7, 32'h0, 4'h0);
    checkOutput("be0_wr_drop", 32'(wr_drop_a), 32'h0);
    checkOutput("be0_q_a", 32'(q_a), 32'h3C);
    checkOutput("be0_q_b", q_b, 32'h3C);

    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 6'(i), 32'hFFFFFFFF, 4'hF);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 6'd9, 32'h0, 4'h0);
    checkOutput("fill_q_b", q_b, 32'hFFFFFFFF);
    applyStimulus(1'b0, 1'b0, 1'b1, 6'd0, 32'h0, 4'h0);
    checkOutput("clr_ready_low", 32'(ready_b), 32'h0);
    cyc = 0;
    for (int i = 1; i <= 200 && cyc == 0; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 6'd0, 32'h0, 4'h0);
      if (ready_b) cyc = i;
    end
    checkOutput("clr_latency", 32'(cyc), 32'd64);
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 6'(i), 32'h0, 4'h0);
      checkOutput("clr_q_a", 32'(q_a), 32'h0);
      checkOutput("clr_q_b", q_b, 32'hDEADBEEF);
    end

    applyStimulus(1'b0, 1'b0, 1'b1, 6'd0, 32'h0, 4'h0);
    for (int i = 0; i < 30; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 6'd0, 32'h0, 4'h0);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 6'd0, 32'h0, 4'h0);
    checkOutput("midclr_rst_ready", 32'(ready_a), 32'h0);
    cyc = 0;
    for (int i = 1; i <= 200 && cyc == 0; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 6'd0, 32'h0, 4'h0);
      if (ready_a) cyc = i;
    end
    checkOutput("midclr_latency", 32'(cyc), 32'd64);
    applyStimulus(1'b0, 1'b0, 1'b0, 6'd9, 32'h0, 4'h0);
    checkOutput("midclr_q_b", q_b, 32'hDEADBEEF);
    checkOutput("midclr_q_a", 32'(q_a), 32'h0);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
